adder_tree: RTL and testbench

- Parameterised, fully pipelined binary adder tree.
- Sums NUM_ADDEND unsigned addends, packed on one flat bus, into a single SUM_LENGTH-bit result.
- Accepts a new addend vector every clock; result appears a fixed number of cycles later.
- Used as a generic multi-operand reduction stage (e.g. accumulation of partial products / sample sums).

---
 rtl/adder_tree.sv | 48 ++++
 tb/tb_adder_tree.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/adder_tree.sv
// Fully pipelined binary adder tree: NUM_ADDEND unsigned addends reduced to one
// SUM_LENGTH-bit total, one new vector per clock, stage_cnt+1 cycles of latency.
`timescale 1ns/1ps

module adder_tree #(
    parameter int ADD_LENGTH = 16,
    parameter int SUM_LENGTH = 32,
    parameter int NUM_ADDEND = 45
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADD_LENGTH*NUM_ADDEND-1:0]   addends,
    output logic [SUM_LENGTH-1:0]              sum
);

    localparam int stage_cnt  = $clog2(NUM_ADDEND);
    localparam int mod_addend = 32'sd1 << stage_cnt;
    localparam int reg_length = (mod_addend << 1) - 32'sd1;

    // Leaves 0..mod_addend-1, then each level toward the root; node n >= mod_addend
    // has children 2*(n-mod_addend) and 2*(n-mod_addend)+1 (heap layout on the leaf count).
    logic [SUM_LENGTH-1:0]            reg_pipeline [0:reg_length-1];
    logic [ADD_LENGTH*mod_addend-1:0] padded_s;

    // Zero padding supplies the constant-0 leaves beyond NUM_ADDEND.
    assign padded_s = (ADD_LENGTH*mod_addend)'(addends);

    // Leaf capture and every adder level advance together on each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 32'sd0; i < reg_length; i++) begin
                reg_pipeline[i] <= '0;
            end
        end else begin
            for (int k = 32'sd0; k < mod_addend; k++) begin
                reg_pipeline[k] <= SUM_LENGTH'(padded_s[k*ADD_LENGTH +: ADD_LENGTH]);
            end
            for (int n = mod_addend; n < reg_length; n++) begin
                reg_pipeline[n] <= reg_pipeline[(n - mod_addend) << 1]
                                 + reg_pipeline[((n - mod_addend) << 1) + 32'sd1];
            end
        end
    end

    // Output is the root register itself.
    assign sum = reg_pipeline[reg_length-1];

endmodule

// File: tb/tb_adder_tree.sv
// Directed bench for adder_tree: default build (45 x 16 -> 32) and a small
// 4 x 16 -> 16 build exercising wrap-around.
`timescale 1ns/1ps

module tb_adder_tree;

    logic          clk = 1'b0;
    logic          rst;
    logic [719:0]  addends;
    logic [31:0]   sum;
    logic [63:0]   addends2;
    logic [15:0]   sum2;

    int tests = 0;
    int fails = 0;

    logic [15:0] pat [0:14];
    string       row;

    adder_tree dut (
        .clk     (clk),
        .rst     (rst),
        .addends (addends),
        .sum     (sum)
    );

    adder_tree #(
        .ADD_LENGTH (16),
        .SUM_LENGTH (16),
        .NUM_ADDEND (4)
    ) dut2 (
        .clk     (clk),
        .rst     (rst),
        .addends (addends2),
        .sum     (sum2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        pat = '{16'h8001, 16'h8002, 16'h8004, 16'h8008, 16'h8010, 16'h8020, 16'h8040,
                16'h8080, 16'h8100, 16'h8200, 16'h8400, 16'h8800, 16'h9000, 16'h8000,
                16'hE000};
        rst      = 1'b1;
        addends  = '0;
        addends2 = '0;

        // Reset state and derived parameters
        #1;
        check("reset_sum_immediate", sum, 32'h0);
        check("stage_cnt", 32'(dut.stage_cnt), 32'd6);
        check("mod_addend", 32'(dut.mod_addend), 32'd64);
        check("reg_length", 32'(dut.reg_length), 32'd127);
        check("small_stage_cnt", 32'(dut2.stage_cnt), 32'd2);
        tick(3);
        for (int i = 0; i < 127; i++) begin
            check($sformatf("reset_entry_%0d", i), dut.reg_pipeline[i], 32'h0);
        end
        check("reset_sum", sum, 32'h0);
        check("reset_small_sum", {16'h0, sum2}, 32'h0);

        // Idle with zero addends after reset release
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            check($sformatf("idle_zero_c%0d", c), sum, 32'h0);
        end

        // Three repeats of the 15-addend pattern
        for (int i = 0; i < 45; i++) begin
            addends[i*16 +: 16] = pat[i % 15];
        end
        tick(6);
        check("pattern_edge6_unchanged", sum, 32'h0);
        tick(1);
        check("pattern_sum", sum, 32'h0017FFFD);
        for (int k = 0; k < 64; k++) begin
            check($sformatf("pattern_leaf_%0d", k), dut.reg_pipeline[k],
                  (k < 45) ? {16'h0, pat[k % 15]} : 32'h0);
        end
        row = "leaves:";
        for (int k = 0; k < 64; k++) row = {row, $sformatf(" %0h", dut.reg_pipeline[k])};
        $display("%s", row);
        row = "levels:";
        for (int k = 64; k < 127; k++) row = {row, $sformatf(" %0h", dut.reg_pipeline[k])};
        $display("%s", row);

        // All-ones vector: latency boundary
        addends = '1;
        tick(6);
        check("allones_edge6_unchanged", sum, 32'h0017FFFD);
        tick(1);
        check("allones_sum", sum, 32'h002CFFD3);

        // Back-to-back vectors, one per cycle
        addends = '0;
        addends[44*16 +: 16] = 16'hFFFF;
        tick(1);
        addends = '0;
        addends[15:0] = 16'h0001;
        tick(1);
        addends = '1;
        tick(5);
        check("b2b_last_addend", sum, 32'h0000FFFF);
        tick(1);
        check("b2b_first_addend", sum, 32'h00000001);
        tick(1);
        check("b2b_allones", sum, 32'h002CFFD3);

        // Asynchronous reset pulse between edges with a full pipeline
        tick(3);
        check("prepulse_sum", sum, 32'h002CFFD3);
        #3;
        rst = 1'b1;
        #1;
        check("pulse_sum", sum, 32'h0);
        for (int i = 0; i < 127; i++) begin
            check($sformatf("pulse_entry_%0d", i), dut.reg_pipeline[i], 32'h0);
        end
        rst = 1'b0;
        tick(6);
        check("postpulse_edge6", sum, 32'h0);
        tick(1);
        check("postpulse_sum", sum, 32'h002CFFD3);

        // Small build: wrap-around modulo 2^16 with 3-edge latency
        addends2 = '1;
        tick(2);
        check("small_edge2_unchanged", {16'h0, sum2}, 32'h0);
        tick(1);
        check("small_wrap_sum", {16'h0, sum2}, 32'h0000FFFC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
